// File: rtl/button_pkg.sv
// Shared types for the push-button / sensor front-end.
`default_nettype none

package button_pkg;

  typedef enum logic [1:0] {
    REL  = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } hold_state_t;

endpackage

`default_nettype wire

// File: rtl/button_channel.sv
// One input channel: synchroniser, debounce, and click / long-press / auto-repeat FSM.
`default_nettype none

module button_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DEB_CYCLES    = 160,
  parameter int LONG_CYCLES   = 65536,
  parameter int REPEAT_CYCLES = 8192,
  parameter bit REP_EN        = 1'b0
) (
  input  logic Clock,
  input  logic nReset,
  input  logic n_in,
  output logic pressed,
  output logic press,
  output logic click,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES);
  localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [REP_W-1:0]       rep_cnt_q, rep_cnt_d;
  logic                   level_q, level_d;
  hold_state_t            state_q, state_d;
  logic                   press_q, press_d;
  logic                   click_q, click_d;
  logic                   long_q, long_d;
  logic                   rep_q, rep_d;
  logic                   raw_pressed;
  logic                   level_rise, level_fall;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], n_in};
    raw_pressed = ~sync_q[SYNC_STAGES-1];

    // Any cycle where the synchronised input agrees with the level restarts the count.
    level_d   = level_q;
    deb_cnt_d = '0;
    if (raw_pressed != level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        level_d = raw_pressed;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_ONE;
      end
    end

    level_rise = level_d & ~level_q;
    level_fall = ~level_d & level_q;

    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    press_d    = 1'b0;
    click_d    = 1'b0;
    long_d     = 1'b0;
    rep_d      = 1'b0;

    // A release always takes priority over a terminal count in the same cycle.
    case (state_q)
      REL: begin
        if (level_rise) begin
          state_d    = HELD;
          press_d    = 1'b1;
          hold_cnt_d = '0;
        end
      end
      HELD: begin
        if (level_fall) begin
          state_d    = REL;
          click_d    = 1'b1;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = LONG;
          long_d     = 1'b1;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
      end
      LONG: begin
        if (level_fall) begin
          state_d   = REL;
          rep_cnt_d = '0;
        end else if (rep_cnt_q == REP_LAST) begin
          rep_cnt_d = '0;
          rep_d     = REP_EN;
        end else begin
          rep_cnt_d = rep_cnt_q + REP_ONE;
        end
      end
      default: begin
        state_d    = REL;
        hold_cnt_d = '0;
        rep_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sync_q     <= '1;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      level_q    <= 1'b0;
      state_q    <= REL;
      press_q    <= 1'b0;
      click_q    <= 1'b0;
      long_q     <= 1'b0;
      rep_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      level_q    <= level_d;
      state_q    <= state_d;
      press_q    <= press_d;
      click_q    <= click_d;
      long_q     <= long_d;
      rep_q      <= rep_d;
    end
  end

  assign pressed      = level_q;
  assign press        = press_q;
  assign click        = click_q;
  assign long_press   = long_q;
  assign repeat_pulse = rep_q;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// N-channel button conditioner: one independent button_channel per active-low input pin.
`default_nettype none

module button_conditioner
  import button_pkg::*;
#(
  parameter int              N_CH          = 4,
  parameter int              SYNC_STAGES   = 2,
  parameter int              DEB_CYCLES    = 160,
  parameter int              LONG_CYCLES   = 65536,
  parameter int              REPEAT_CYCLES = 8192,
  parameter logic [N_CH-1:0] REPEAT_EN     = '0
) (
  input  logic            Clock,
  input  logic            nReset,
  input  logic [N_CH-1:0] nIn,
  output logic [N_CH-1:0] pressed,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] click,
  output logic [N_CH-1:0] long_press,
  output logic [N_CH-1:0] repeat_pulse
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("button_conditioner: SYNC_STAGES must be at least 2");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("button_conditioner: DEB_CYCLES must be at least 1");
  end
  if (LONG_CYCLES <= DEB_CYCLES) begin : g_bad_long
    $error("button_conditioner: LONG_CYCLES must exceed DEB_CYCLES");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_rep
    $error("button_conditioner: REPEAT_CYCLES must be at least 1");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEB_CYCLES   (DEB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .REP_EN       (REPEAT_EN[i])
    ) u_channel (
      .Clock       (Clock),
      .nReset      (nReset),
      .n_in        (nIn[i]),
      .pressed     (pressed[i]),
      .press       (press[i]),
      .click       (click[i]),
      .long_press  (long_press[i]),
      .repeat_pulse(repeat_pulse[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random button activity against an event-timing model.
`default_nettype none

module tb_button_conditioner;

  localparam int         N     = 2;
  localparam int         SYNC  = 2;
  localparam int         DEB   = 4;
  localparam int         LONGC = 20;
  localparam int         REP   = 5;
  localparam logic [1:0] REPEN = 2'b10;
  localparam int         MAXT  = 8192;

  logic         Clock;
  logic         nReset;
  logic [N-1:0] nIn;
  logic [N-1:0] pressed, press, click, long_press, repeat_pulse;

  button_conditioner #(
    .N_CH         (N),
    .SYNC_STAGES  (SYNC),
    .DEB_CYCLES   (DEB),
    .LONG_CYCLES  (LONGC),
    .REPEAT_CYCLES(REP),
    .REPEAT_EN    (REPEN)
  ) dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .nIn         (nIn),
    .pressed     (pressed),
    .press       (press),
    .click       (click),
    .long_press  (long_press),
    .repeat_pulse(repeat_pulse)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Model: raw input samples indexed by edge number; all timing derived from them arithmetically.
  logic [N-1:0] hist [0:MAXT-1];
  int           t     = 0;
  int           rst_t = 0;
  logic [N-1:0] lvl   = '0;
  int           press_t [N];
  logic [N-1:0] e_pressed = '0, e_press = '0, e_click = '0, e_long = '0, e_rep = '0;

  // Synchronised input visible after edge j: the sample from SYNC-1 edges earlier, released while in reset.
  function automatic logic s_at(int ch, int j);
    int idx;
    idx = j - SYNC + 1;
    if (idx <= rst_t) return 1'b1;
    return hist[idx][ch];
  endfunction

  task automatic model_edge(input logic [N-1:0] n, input logic r);
    bit flip;
    int d;
    t = t + 1;
    if (t < MAXT) hist[t] = n;
    e_press = '0; e_click = '0; e_long = '0; e_rep = '0;
    if (!r) begin
      rst_t = t;
      lvl   = '0;
    end else begin
      for (int ch = 0; ch < N; ch++) begin
        // Level flips once the previous DEB synchronised samples all disagree with it.
        flip = 1'b1;
        for (int j = t - DEB; j < t; j++)
          if (~s_at(ch, j) == lvl[ch]) flip = 1'b0;
        if (flip && !lvl[ch]) begin
          e_press[ch] = 1'b1;
          press_t[ch] = t;
        end else if (flip && lvl[ch]) begin
          if (t - press_t[ch] <= LONGC) e_click[ch] = 1'b1;
        end else if (lvl[ch]) begin
          d = t - press_t[ch];
          if (d == LONGC) e_long[ch] = 1'b1;
          if (d > LONGC && ((d - LONGC) % REP) == 0) e_rep[ch] = REPEN[ch];
        end
        if (flip) lvl[ch] = ~lvl[ch];
      end
    end
    e_pressed = lvl;
  endtask

  task automatic step(input logic [N-1:0] n, input logic r);
    @(negedge Clock);
    nIn    = n;
    nReset = r;
    @(posedge Clock);
    model_edge(n, r);
    #1;
    checks++;
    assert (pressed === e_pressed) else begin
      errors++; $error("FAIL pressed t=%0d got %b exp %b", t, pressed, e_pressed);
    end
    checks++;
    assert (press === e_press) else begin
      errors++; $error("FAIL press t=%0d got %b exp %b", t, press, e_press);
    end
    checks++;
    assert (click === e_click) else begin
      errors++; $error("FAIL click t=%0d got %b exp %b", t, click, e_click);
    end
    checks++;
    assert (long_press === e_long) else begin
      errors++; $error("FAIL long_press t=%0d got %b exp %b", t, long_press, e_long);
    end
    checks++;
    assert (repeat_pulse === e_rep) else begin
      errors++; $error("FAIL repeat t=%0d got %b exp %b", t, repeat_pulse, e_rep);
    end
  endtask

  task automatic hold(input logic [N-1:0] n, input int cycles);
    for (int i = 0; i < cycles; i++) step(n, 1'b1);
  endtask

  int           rem [N];
  logic [N-1:0] cur;

  initial begin
    nIn    = '1;
    nReset = 1'b0;
    for (int i = 0; i < 3; i++) step(2'b11, 1'b0);
    hold(2'b11, 3);

    // Clean short press on ch0.
    hold(2'b10, 10);
    hold(2'b11, 15);
    // Glitches on ch0 shorter than the debounce window.
    hold(2'b10, 3);
    hold(2'b11, 1);
    for (int g = 0; g < 3; g++) begin
      hold(2'b10, 3);
      hold(2'b11, 1);
    end
    hold(2'b11, 8);
    // Long hold with auto-repeat on ch1, then without on ch0.
    hold(2'b01, 45);
    hold(2'b11, 12);
    hold(2'b10, 45);
    hold(2'b11, 12);
    // Both channels together, released on different cycles.
    hold(2'b00, 12);
    hold(2'b01, 6);
    hold(2'b11, 12);
    // Release coinciding with the long-press terminal on ch0, and a repeat terminal on ch1.
    hold(2'b10, 20);
    hold(2'b11, 10);
    hold(2'b01, 25);
    hold(2'b11, 10);
    // Reset while ch1 is long-held, input still low afterwards.
    hold(2'b01, 30);
    for (int i = 0; i < 3; i++) step(2'b01, 1'b0);
    hold(2'b01, 15);
    hold(2'b11, 10);

    // Random activity: mostly short bursts and glitches, sometimes long holds.
    rem = '{0, 0};
    cur = '1;
    for (int c = 0; c < 1500; c++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (rem[ch] == 0) begin
          cur[ch] = 1'($urandom_range(0, 1));
          rem[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                : int'($urandom_range(1, 8));
        end
        rem[ch] = rem[ch] - 1;
      end
      step(cur, (c >= 700 && c < 702) ? 1'b0 : 1'b1);
    end
    hold(2'b11, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/button_conditioner.md
# button_conditioner

Parametrised front-end that turns N asynchronous active-low push-button or sensor inputs into clean, clock-domain-local events. It sits between the chip pins and the cycle computer's mode, trip and wheel-size logic. It replaces the fixed two-stage-sync, deglitch and pulse-gen chain. Per channel it adds configurable debounce, click vs long-press discrimination and optional auto-repeat while held.

## Interface
- N_CH, 4: number of independent input channels
- SYNC_STAGES, 2: synchroniser flops per channel, ≥2
- DEB_CYCLES, 160: consecutive stable cycles needed to accept a level change, ≥1
- LONG_CYCLES, 65536: cycles a debounced press must last to count as a long press (2 s at 32.768 kHz), > DEB_CYCLES
- REPEAT_CYCLES, 8192: auto-repeat period after a long press, ≥1
- REPEAT_EN, '0 (N_CH bits): per-channel auto-repeat enable mask
- Clock  in  1  system clock
- nReset  in  1  asynchronous, active-low reset
- nIn  in  N_CH  raw asynchronous inputs, low = pressed
- pressed  out  N_CH  debounced level, 1 = pressed
- press  out  N_CH  one-cycle pulse on debounced press
- click  out  N_CH  one-cycle pulse on release of a press shorter than LONG_CYCLES
- long_press  out  N_CH  one-cycle pulse when a press reaches LONG_CYCLES
- repeat  out  N_CH  one-cycle pulse every REPEAT_CYCLES while long-held, gated by REPEAT_EN

## Operation
- Channels are fully independent. Bit i of every output refers only to nIn[i].
- Synchroniser: SYNC_STAGES flops per channel, reset to 1 (released). The last stage output is s.
- Debounce counter deb_cnt, width $clog2(DEB_CYCLES+1):
  - Increments while s differs from the current debounced level.
  - Clears to 0 on any cycle where s equals the level, so a glitch shorter than DEB_CYCLES is discarded.
  - When the counter reaches DEB_CYCLES-1 and s still differs, the level flips on the next edge and deb_cnt clears.
- Hold FSM per channel: states REL, HELD, LONG. Reset state is REL.
  - REL → HELD on the level rising. press pulses in the same cycle the level rises. hold_cnt clears.
  - HELD: hold_cnt increments each cycle. When hold_cnt reaches LONG_CYCLES-1, go to LONG, pulse long_press and clear rep_cnt.
  - HELD → REL on the level falling: pulse click.
  - LONG: rep_cnt increments. When rep_cnt reaches REPEAT_CYCLES-1, pulse repeat (only if REPEAT_EN[i]) and wrap rep_cnt to 0.
  - LONG → REL on the level falling: no click, no pulse.
- pressed = 1 in HELD and LONG. It is registered and equals the debounced level.
- All outputs are registered, with no combinational path from nIn.
- Counter widths: hold_cnt $clog2(LONG_CYCLES); rep_cnt $clog2(REPEAT_CYCLES+1). Counters never overflow: each clears on its terminal value or on state exit.

## Timing
- Reset values: pressed, press, click, long_press, repeat all 0; sync flops 1; counters 0; FSM REL.
- Press latency: nIn[i] falls before edge k (meets setup). The sync chain output s changes at edge k+SYNC_STAGES-1. pressed and press assert at edge k+SYNC_STAGES-1+DEB_CYCLES.
- Release latency is symmetric. click asserts at the same edge pressed falls.
- long_press asserts LONG_CYCLES cycles after press, provided the level has not fallen first.
- First repeat comes REPEAT_CYCLES cycles after long_press, then every REPEAT_CYCLES cycles.
- Level falling in the same cycle hold_cnt hits terminal: the release wins. The FSM goes to REL, click pulses, long_press does not.
- Level falling in the same cycle rep_cnt hits terminal: the release wins and no repeat pulses.
- Reset asserted mid-press: everything returns to reset values immediately. If the input is still low after reset release, a fresh press is produced after the full latency.
- Each pulse is exactly one cycle. At most one of press/click/long_press/repeat is high per channel per cycle.

## Structure
- Package button_pkg holds typedef enum logic [1:0] {REL, HELD, LONG} hold_state_t.
- Sub-module button_channel: one sync chain, debounce, FSM and counters, parametrised by SYNC_STAGES, DEB_CYCLES, LONG_CYCLES, REPEAT_CYCLES, REP_EN.
- Top level instantiates it with a generate loop over N_CH.
- Elaboration-time assertions check the parameter constraints.

## Test plan
Bench parameters: N_CH=2, SYNC_STAGES=2, DEB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5, REPEAT_EN=2'b10.
- Clean press of ch0 held 10 cycles, then released → pressed rises 5 edges after the input falls. press is 1 cycle. click pulses when pressed falls. No long_press.
- ch0 low-glitch of 3 cycles, then 3-cycle glitches separated by 1 high cycle → pressed stays 0, no pulses.
- ch1 held 40 cycles after press → long_press at press+20. repeat at +25, +30, +35, +40 while held. No click on release.
- ch0 held 40 cycles (REPEAT_EN=0) → long_press only, no repeat.
- ch0 and ch1 pressed together, released on different cycles → independent press/click timing per channel, with no cross-talk.
- nReset pulsed while ch1 is in LONG with the input still low → all outputs 0 during reset. After release, press fires again 5 cycles later.
